// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle control FSM for the single-datapath MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM/WB for R-type, lw, sw and beq, and halts on a
// memory that stays not-ready for MEM_TIMEOUT consecutive cycles.
// Optional performance counters are compiled in with `define MIPS_CTRL_PERF_CNT_EN.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              ir_write,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic              reg_dst,
  output logic              reg_write,
  output logic              alu_src,
  output logic [3:0]        alu_control,
  output logic              mem_write,
  output logic              mem_read,
  output logic              mem_to_reg,
  output logic              illegal,
  output logic              mem_err,
`ifdef MIPS_CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retired_cnt,
`endif
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Wide enough to hold MEM_TIMEOUT-1; with the timeout disabled it just wraps.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t            state_q, state_d;
  logic [5:0]        opcode_q, opcode_d;
  logic [5:0]        funct_q, funct_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic              memErr_q, memErr_d;

  logic              decLegal;
  logic              timeoutHit;
  logic [3:0]        aluCode;
  logic              isR, isLw, isSw, isBeq;

  // The branch flag is consumed by the datapath and the register/immediate
  // fields are routed there directly; the controller only looks at opcode/funct.
  logic unusedInputs;
  assign unusedInputs = ^{zero, instr[25:6]};

`ifndef MIPS_CTRL_PERF_CNT_EN
  localparam int unusedCntW = CNT_W;
`endif

  assign isR   = (opcode_q == OP_RTYPE);
  assign isLw  = (opcode_q == OP_LW);
  assign isSw  = (opcode_q == OP_SW);
  assign isBeq = (opcode_q == OP_BEQ);

  // The current not-ready cycle is the MEM_TIMEOUT-th in a row when the counter already holds MEM_TIMEOUT-1.
  assign timeoutHit = (MEM_TIMEOUT > 0) && !mem_ready &&
                      (waitCnt_q == WAIT_W'(MEM_TIMEOUT - 1));

  // Classify the live instruction word during DECODE.
  always_comb begin
    decLegal = 1'b0;
    case (instr[31:26])
      OP_LW, OP_SW, OP_BEQ: decLegal = 1'b1;
      OP_RTYPE: begin
        case (instr[5:0])
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: decLegal = 1'b1;
          default:                               decLegal = 1'b0;
        endcase
      end
      default: decLegal = 1'b0;
    endcase
  end

  // ALU operation for the latched instruction, held from EXEC through WB.
  always_comb begin
    aluCode = ALU_AND;
    case (opcode_q)
      OP_LW, OP_SW: aluCode = ALU_ADD;
      OP_BEQ:       aluCode = ALU_SUB;
      default: begin
        case (funct_q)
          FN_ADD:  aluCode = ALU_ADD;
          FN_SUB:  aluCode = ALU_SUB;
          FN_AND:  aluCode = ALU_AND;
          FN_OR:   aluCode = ALU_OR;
          FN_SLT:  aluCode = ALU_SLT;
          default: aluCode = ALU_AND;
        endcase
      end
    endcase
  end

  // Next-state and control outputs; everything defaults to 0 so IDLE and HALT drive nothing.
  always_comb begin
    state_d       = state_q;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src       = 1'b0;
    alu_control   = 4'b0000;
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    mem_to_reg    = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        if (mem_ready)       state_d = DECODE;
        else if (timeoutHit) state_d = HALT;
      end
      DECODE: begin
        if (decLegal) begin
          state_d = EXEC;
        end else begin
          illegal = 1'b1;
          state_d = FETCH;
        end
      end
      EXEC: begin
        alu_control = aluCode;
        alu_src     = isLw | isSw;
        if (isBeq) begin
          pc_write_cond = 1'b1;
          state_d       = FETCH;
        end else if (isLw | isSw) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        alu_control = aluCode;
        alu_src     = 1'b1;
        mem_read    = isLw;
        mem_write   = isSw;
        if (mem_ready)       state_d = isLw ? WB : FETCH;
        else if (timeoutHit) state_d = HALT;
      end
      WB: begin
        alu_control = aluCode;
        reg_write   = 1'b1;
        reg_dst     = isR;
        mem_to_reg  = isLw;
        alu_src     = isLw;
        state_d     = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Field latching, wait counting and the sticky memory error flag.
  always_comb begin
    opcode_d = opcode_q;
    funct_d  = funct_q;
    if (state_q == DECODE) begin
      opcode_d = instr[31:26];
      funct_d  = instr[5:0];
    end
    if (state_d != state_q)
      waitCnt_d = '0;
    else if (((state_q == FETCH) || (state_q == MEM)) && !mem_ready)
      waitCnt_d = waitCnt_q + WAIT_W'(1);
    else
      waitCnt_d = '0;
    memErr_d = memErr_q | (state_d == HALT);
  end

  // State and latched-field registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      funct_q   <= '0;
      waitCnt_q <= '0;
      memErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct_q   <= funct_d;
      waitCnt_q <= waitCnt_d;
      memErr_q  <= memErr_d;
    end
  end

  assign state   = state_q;
  assign mem_err = memErr_q;

`ifdef MIPS_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycleCnt_q, retiredCnt_q;
  logic             retire;

  assign retire = (state_q == WB) ||
                  ((state_q == MEM) && isSw && mem_ready) ||
                  ((state_q == EXEC) && isBeq);

  // Performance counters: active cycles and retired instructions, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycleCnt_q   <= '0;
      retiredCnt_q <= '0;
    end else begin
      if ((state_q != IDLE) && (state_q != HALT))
        cycleCnt_q <= cycleCnt_q + CNT_W'(1);
      if (retire)
        retiredCnt_q <= retiredCnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycleCnt_q;
  assign retired_cnt = retiredCnt_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: scoreboard bench for the multicycle MIPS controller.
// Each stimulus cycle pushes the expected control vector; a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

  localparam int TIMEOUT = 4;

  localparam int K_R   = 0;
  localparam int K_LW  = 1;
  localparam int K_SW  = 2;
  localparam int K_BEQ = 3;
  localparam int K_ILL = 4;

  typedef struct packed {
    logic [2:0] st;
    logic       irW;
    logic       pcW;
    logic       pcWC;
    logic       regDst;
    logic       regWrite;
    logic       aluSrc;
    logic [3:0] aluCtl;
    logic       memW;
    logic       memR;
    logic       memToReg;
    logic       illegal;
    logic       memErr;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        ir_write, pc_write, pc_write_cond, reg_dst, reg_write, alu_src;
  logic [3:0]  alu_control;
  logic        mem_write, mem_read, mem_to_reg, illegal, mem_err;
  logic [2:0]  state;
`ifdef MIPS_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  int    vectors    = 0;
  int    miscompares = 0;
  ctrl_t expQ[$];
  string nameQ[$];
  ctrl_t monExp;
  string monName;
  bit    haltedFlag;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src(alu_src),
    .alu_control(alu_control), .mem_write(mem_write), .mem_read(mem_read),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .mem_err(mem_err),
`ifdef MIPS_CTRL_PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  // Instruction class straight from the supported-instruction tables.
  function automatic int kindOf(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'b100011) return K_LW;
    if (op == 6'b101011) return K_SW;
    if (op == 6'b000100) return K_BEQ;
    if (op == 6'b000000 && (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}))
      return K_R;
    return K_ILL;
  endfunction

  function automatic logic [3:0] aluFor(input logic [31:0] ins);
    int k;
    k = kindOf(ins);
    if (k == K_LW || k == K_SW) return 4'b0010;
    if (k == K_BEQ) return 4'b0110;
    case (ins[5:0])
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic ctrl_t blank(input logic [2:0] st);
    ctrl_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic ctrl_t expIdle();
    return blank(3'd0);
  endfunction

  function automatic ctrl_t expHalt();
    ctrl_t e;
    e = blank(3'd6);
    e.memErr = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t expFetch(input logic rdy);
    ctrl_t e;
    e = blank(3'd1);
    e.memR = 1'b1;
    e.irW  = rdy;
    e.pcW  = rdy;
    return e;
  endfunction

  function automatic ctrl_t expDecode(input logic [31:0] ins);
    ctrl_t e;
    e = blank(3'd2);
    e.illegal = (kindOf(ins) == K_ILL);
    return e;
  endfunction

  function automatic ctrl_t expExec(input logic [31:0] ins);
    ctrl_t e;
    int k;
    k = kindOf(ins);
    e = blank(3'd3);
    e.aluCtl = aluFor(ins);
    e.aluSrc = (k == K_LW || k == K_SW);
    e.pcWC   = (k == K_BEQ);
    return e;
  endfunction

  function automatic ctrl_t expMem(input logic [31:0] ins);
    ctrl_t e;
    e = blank(3'd4);
    e.aluCtl = 4'b0010;
    e.aluSrc = 1'b1;
    e.memR   = (kindOf(ins) == K_LW);
    e.memW   = (kindOf(ins) == K_SW);
    return e;
  endfunction

  function automatic ctrl_t expWb(input logic [31:0] ins);
    ctrl_t e;
    e = blank(3'd5);
    e.aluCtl   = aluFor(ins);
    e.regWrite = 1'b1;
    e.regDst   = (kindOf(ins) == K_R);
    e.memToReg = (kindOf(ins) == K_LW);
    e.aluSrc   = (kindOf(ins) == K_LW);
    return e;
  endfunction

  function automatic ctrl_t sampleDut();
    ctrl_t a;
    a.st = state;             a.irW = ir_write;        a.pcW = pc_write;
    a.pcWC = pc_write_cond;   a.regDst = reg_dst;      a.regWrite = reg_write;
    a.aluSrc = alu_src;       a.aluCtl = alu_control;  a.memW = mem_write;
    a.memR = mem_read;        a.memToReg = mem_to_reg; a.illegal = illegal;
    a.memErr = mem_err;
    return a;
  endfunction

  task automatic checkOutput(input string n, input ctrl_t e);
    ctrl_t a;
    a = sampleDut();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("[TB] FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
               n, a.st, a, e.st, e);
    end
  endtask

  // Drive one cycle of inputs just after the edge and queue the expected outputs for it.
  task automatic applyStimulus(input logic [31:0] ins, input logic rdy,
                               input ctrl_t e, input string n);
    @(posedge clk);
    #1;
    instr     = ins;
    mem_ready = rdy;
    zero      = 1'($urandom);
    expQ.push_back(e);
    nameQ.push_back(n);
  endtask

  // Memory handshake phase: some not-ready cycles, then completion unless the timeout fires first.
  task automatic memPhase(input bit isFetch, input logic [31:0] ins, input int waits,
                          output bit halted);
    halted = 1'b0;
    for (int i = 0; i < waits; i++) begin
      applyStimulus($urandom, 1'b0, isFetch ? expFetch(1'b0) : expMem(ins),
                    isFetch ? "fetch_wait" : "mem_wait");
      if (i + 1 == TIMEOUT) begin
        halted = 1'b1;
        return;
      end
    end
    applyStimulus($urandom, 1'b1, isFetch ? expFetch(1'b1) : expMem(ins),
                  isFetch ? "fetch_done" : "mem_done");
  endtask

  // Whole instruction from FETCH to its last state.
  task automatic runInstr(input logic [31:0] ins, input int fw, input int mw,
                          output bit halted);
    int k;
    k = kindOf(ins);
    memPhase(1'b1, ins, fw, halted);
    if (halted) return;
    applyStimulus(ins, 1'($urandom), expDecode(ins), "decode");
    if (k == K_ILL) return;
    applyStimulus($urandom, 1'($urandom), expExec(ins), "exec");
    if (k == K_BEQ) return;
    if (k == K_LW || k == K_SW) begin
      memPhase(1'b0, ins, mw, halted);
      if (halted || k == K_SW) return;
    end
    applyStimulus($urandom, 1'($urandom), expWb(ins), "wb");
  endtask

  task automatic resetPulse();
    applyStimulus($urandom, 1'b0, expIdle(), "reset_assert");
    rst = 1'b1;
    applyStimulus($urandom, 1'b0, expIdle(), "reset_release");
    rst = 1'b0;
  endtask

  function automatic logic [31:0] randomInstr();
    logic [31:0] w;
    logic [5:0]  fns [5];
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    w = $urandom;
    case ($urandom_range(0, 5))
      0: begin w[31:26] = 6'b000000; w[5:0] = fns[$urandom_range(0, 4)]; end
      1: w[31:26] = 6'b100011;
      2: w[31:26] = 6'b101011;
      3: w[31:26] = 6'b000100;
      4: w[31:26] = 6'b000000;
      default: ;
    endcase
    return w;
  endfunction

  // Monitor: compare the DUT against the oldest queued expectation, mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      monExp  = expQ.pop_front();
      monName = nameQ.pop_front();
      checkOutput(monName, monExp);
    end
  end

  initial begin
    rst = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b0;
    #1 rst = 1'b1;
    applyStimulus(32'h0, 1'b1, expIdle(), "reset_idle");
    applyStimulus(32'h0, 1'b1, expIdle(), "reset_idle");
    applyStimulus(32'h0, 1'b0, expIdle(), "reset_release");
    rst = 1'b0;

    runInstr(32'h00430820, 0, 0, haltedFlag);
    runInstr(32'h8C410000, 0, 0, haltedFlag);
    runInstr(32'hAC410000, 0, 3, haltedFlag);
    runInstr(32'h10220003, 0, 0, haltedFlag);
    runInstr(32'hFC000000, 0, 0, haltedFlag);
    runInstr(32'h00430822, 0, 0, haltedFlag);
    runInstr(32'h0043082A, 0, 0, haltedFlag);
    runInstr(32'h8C410000, TIMEOUT - 1, TIMEOUT - 1, haltedFlag);

    for (int i = 0; i < 60; i++)
      runInstr(randomInstr(), $urandom_range(0, TIMEOUT - 1),
               $urandom_range(0, TIMEOUT - 1), haltedFlag);

    // Asynchronous reset in the middle of a lw memory access.
    applyStimulus($urandom, 1'b1, expFetch(1'b1), "fetch_done");
    applyStimulus(32'h8C410000, 1'b1, expDecode(32'h8C410000), "decode");
    applyStimulus($urandom, 1'b1, expExec(32'h8C410000), "exec");
    applyStimulus($urandom, 1'b0, expMem(32'h8C410000), "mem_wait");
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset", expIdle());
    applyStimulus($urandom, 1'b1, expIdle(), "reset_hold");
    applyStimulus($urandom, 1'b1, expIdle(), "reset_release");
    rst = 1'b0;
    runInstr(32'h00430820, 0, 0, haltedFlag);

    // Fetch timeout: HALT is sticky until reset regardless of mem_ready.
    runInstr(32'h00430820, TIMEOUT, 0, haltedFlag);
    for (int i = 0; i < 4; i++)
      applyStimulus($urandom, 1'($urandom), expHalt(), "halt");
    resetPulse();
    runInstr(32'h10220003, 0, 0, haltedFlag);

    // Memory-stage timeout on a store.
    runInstr(32'hAC410000, 1, TIMEOUT, haltedFlag);
    for (int i = 0; i < 3; i++)
      applyStimulus($urandom, 1'b1, expHalt(), "halt");
    resetPulse();
    runInstr(32'h8C410000, 0, 0, haltedFlag);

    for (int i = 0; i < 10 && expQ.size() != 0; i++)
      @(posedge clk);
    @(posedge clk);
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore/Mealy multicycle control FSM that sequences the single-datapath MIPS core.
- Decodes opcode/funct from the instruction register and drives the datapath control set: RegDst, RegWrite, ALUSrc, ALUcontrol, MemWrite, MemRead, MemToReg, plus IR/PC write enables.
- Supports R-type (add/sub/and/or/slt), lw, sw and beq.
- Handshakes with memory through mem_ready and halts on a memory timeout.

Parameters:
MEM_TIMEOUT, 16, consecutive not-ready cycles in FETCH/MEM before HALT; 0 disables the timeout
CNT_W, 32, width of performance counters (only with PERF_CNT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
instr  input  32  current instruction register contents, stable from DECODE onward
zero  input  1  ALU zero flag from datapath
mem_ready  input  1  memory completes the current read/write this cycle
ir_write  output  1  load instruction register
pc_write  output  1  PC <= PC+4
pc_write_cond  output  1  PC <= branch target if zero
reg_dst  output  1  RegDst
reg_write  output  1  RegWrite
alu_src  output  1  ALUSrc (1 = sign-extended immediate)
alu_control  output  4  ALUcontrol
mem_write  output  1  MemWrite
mem_read  output  1  MemRead
mem_to_reg  output  1  MemToReg
illegal  output  1  one-cycle pulse, unsupported opcode/funct
mem_err  output  1  sticky, memory timeout occurred
state  output  3  current state code

Behaviour:
- Clock is clk. Reset is rst: one clock, reset asynchronous and active-high. Reset forces state IDLE, latched opcode/funct = 0, wait counter = 0, mem_err = 0. All outputs are 0 while in IDLE.
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE -> FETCH unconditionally on the first clock after rst deasserts.
- FETCH:
  - mem_read=1.
  - ir_write=pc_write=mem_ready (Mealy).
  - mem_ready=1 -> DECODE; otherwise stay in FETCH.
- DECODE:
  - Latch opcode=instr[31:26] and funct=instr[5:0].
  - Supported opcodes: 000000 (R), 100011 (lw), 101011 (sw), 000100 (beq).
  - Supported R funct values: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unsupported opcode/funct -> illegal=1 for this cycle, next state FETCH (instruction skipped; PC already advanced).
  - Supported -> EXEC.
- alu_control encoding: add=0010, sub=0110, and=0000, or=0001, slt=0111. It is held from EXEC through WB:
  - lw/sw: add.
  - beq: sub.
  - R-type: decoded from funct.
- EXEC:
  - alu_src=1 for lw/sw, 0 otherwise.
  - beq: pc_write_cond=1, next FETCH.
  - lw/sw: next MEM.
  - R-type: next WB.
- MEM:
  - lw: mem_read=1. sw: mem_write=1. alu_src=1 held.
  - mem_ready=1 -> WB for lw, FETCH for sw; otherwise stay.
- WB:
  - reg_write=1 for exactly one cycle.
  - R-type: reg_dst=1, mem_to_reg=0.
  - lw: reg_dst=0, mem_to_reg=1, alu_src=1.
  - Next state FETCH.
- Latency with mem_ready constantly 1: R-type 4 cycles, lw 5, sw 4, beq 3 (FETCH through last state).
- Wait counter:
  - Increments each FETCH/MEM cycle with mem_ready=0; clears on any state change.
  - If MEM_TIMEOUT>0 and the MEM_TIMEOUT-th consecutive not-ready cycle occurs -> HALT, mem_err=1.
  - A cycle with mem_ready=1 never times out.
- HALT: all control outputs 0, mem_err=1. Left only by rst.
- Never assert simultaneously: mem_read with mem_write; reg_write outside WB.
- instr changes outside DECODE are ignored, because fields are latched.
- rst asserted mid-instruction -> immediate IDLE, all outputs 0 asynchronously; no partial write completes afterwards.

Optional Feature:
- Macro: MIPS_CTRL_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_cnt[CNT_W-1:0] and retired_cnt[CNT_W-1:0], both reset to 0.
  - cycle_cnt increments every cycle outside IDLE/HALT.
  - retired_cnt increments on WB exit, sw MEM completion and beq EXEC; illegal instructions do not count.
  - Both counters wrap modulo 2^CNT_W.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then instr=0x00430820 (add $1,$2,$3), mem_ready=1 -> states 1,2,3,5,1; alu_control=0010 in EXEC/WB; reg_write=1, reg_dst=1 only in WB.
- instr=0x8C410000 (lw $1,0($2)), mem_ready=1 -> states 1,2,3,4,5; mem_read=1 in MEM; WB shows reg_write=1, mem_to_reg=1, alu_src=1.
- instr=0xAC410000 (sw), mem_ready low for 3 MEM cycles then high -> MEM held 4 cycles with mem_write=1, then FETCH; reg_write never 1.
- instr=0x10220003 (beq) -> EXEC shows alu_control=0110, pc_write_cond=1; next state FETCH; total 3 cycles.
- instr opcode 111111 -> illegal pulse in DECODE, next FETCH; MEM_TIMEOUT=4 with mem_ready=0 in FETCH -> HALT after 4 cycles, mem_err=1 until rst.
- rst asserted during lw MEM state -> state=0 and all outputs 0 without waiting for a clock edge; FETCH resumes one cycle after release.
